serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial unsigned subtractor computing `A - B - Bin` one bit per clock, LSB first, through a single full-subtractor cell. It is the inverse of the team's combinational ripple-carry adder. It trades latency for area, and it is the datapath primitive for the upcoming multi-cycle ALU and restoring-divider work. A start/busy/valid handshake frames each operation.

## Interface
Parameters:
- `WIDTH`, default 4: operand and result width in bits; legal range is 2 or more.

Ports:
- `i_w_clk`, input, 1: the only clock; everything is sampled on its rising edge.
- `i_w_rst_n`, input, 1: asynchronous, active-low reset.
- `i_w_start`, input, 1: request a new operation; it is sampled only in IDLE or DONE.
- `i_w_a`, input, WIDTH: minuend, latched on an accepted start.
- `i_w_b`, input, WIDTH: subtrahend, latched on an accepted start.
- `i_w_bin`, input, 1: borrow-in, latched on an accepted start.
- `o_w_busy`, output, 1: high while in SHIFT.
- `o_w_valid`, output, 1: one-cycle pulse, high exactly while in DONE.
- `o_w_diff`, output, WIDTH: result register.
- `o_w_bout`, output, 1: final borrow-out register.

## Operation
- The FSM has three states:
  - IDLE: waits for a start.
  - SHIFT: processes one bit per cycle.
  - DONE: presents the result for one cycle.
- IDLE with `i_w_start` = 1 goes to SHIFT.
  - The operands go into internal shift registers.
  - The borrow flop is loaded with `i_w_bin`.
  - The bit counter is cleared.
- Each SHIFT cycle does the following:
  - The cell computes `d = a0 ^ b0 ^ br` and `br' = (~a0 & b0) | (~(a0 ^ b0) & br)`.
  - `d` shifts into the MSB of the partial-result register.
  - The operands shift right by one.
  - The borrow flop takes `br'`.
  - The counter increments.
- After the SHIFT cycle with counter = WIDTH-1, the FSM goes to DONE.
  - `o_w_diff` takes the full partial result, with the final bit included.
  - `o_w_bout` takes the final borrow.
- DONE goes to IDLE when `i_w_start` = 0. When `i_w_start` = 1 it goes straight to SHIFT and loads the new operands (back-to-back operation).
- `i_w_start` in SHIFT is ignored. It is neither queued nor allowed to corrupt the operation in flight.
- Arithmetic is unsigned, modulo 2^WIDTH.
  - `{o_w_bout, o_w_diff}` = `{1'b0, A} - B - Bin` in (WIDTH+1)-bit two's complement.
  - `o_w_bout` = 1 exactly when `A < B + Bin`.
- `o_w_diff` and `o_w_bout` change only on entry to DONE and hold their values until the next DONE.
- Input operands are don't-care outside the accepting cycle.

## Timing
- Reset values are asserted immediately on `i_w_rst_n` = 0, independent of the clock:
  - state = IDLE;
  - `o_w_busy` = 0;
  - `o_w_valid` = 0;
  - `o_w_diff` = 0;
  - `o_w_bout` = 0;
  - counter, operand and borrow registers = 0.
- Latency: if start is sampled at edge E, then `o_w_busy` is high from E to E+WIDTH, and `o_w_valid` is high from E+WIDTH to E+WIDTH+1. The result is therefore visible WIDTH+1 cycles after the start cycle.
- Throughput with back-to-back starts is one result every WIDTH+1 cycles.
- Reset in the middle of an operation aborts it. After reset release no valid pulse appears for the aborted operation, and the block is in IDLE on the first edge after deassertion.
- Reset deassertion is synchronized externally; the block does not add a release synchronizer.

## Configuration
- `SERIAL_SUB_SATURATE_EN`, defined: on entry to DONE with a final borrow of 1, `o_w_diff` is forced to 0 (unsigned clamp) and `o_w_bout` still reports 1.
- Undefined: `o_w_diff` is the wrapped modulo-2^WIDTH result.
- The macro does not change latency, handshake, or port list.

## Structure
- Shared package/include `serial_sub_pkg` holds:
  - the state encoding constants `ST_IDLE`=2'd0, `ST_SHIFT`=2'd1, `ST_DONE`=2'd2;
  - the counter-width function `clog2(WIDTH)`.
- One natural sub-module, `full_subtractor`: purely combinational, ports a, b, bin → d, bout. It is instantiated once and is reusable by the divider.
- Counter width is `clog2(WIDTH)`. The terminal compare is against WIDTH-1 and has no wrap dependence.

## Test plan
All scenarios use WIDTH=4.
- Basic operation: A=9, B=3, Bin=0, start at edge E.
  - Required: busy high from E to E+4.
  - Required: valid high for one cycle at E+4.
  - Required: diff=6, bout=0.
- Underflow: A=3, B=9, Bin=0.
  - Required without the macro: diff=0xA, bout=1.
  - Required with `SERIAL_SUB_SATURATE_EN`: diff=0, bout=1.
- Borrow-in: A=0, B=0, Bin=1.
  - Required without the macro: diff=0xF, bout=1.
- Ignored start: start A=5, B=1; pulse start with A=0xF, B=0 two cycles later, during SHIFT.
  - Required: a single valid pulse, with diff=4, bout=0.
- Back-to-back: keep start high through DONE, with new operands A=0xF, B=0xE.
  - Required: second valid pulse exactly 5 cycles after the first, with diff=1.
- Reset mid-operation: assert `i_w_rst_n`=0 two cycles into SHIFT.
  - Required: all outputs go to 0 asynchronously.
  - Required: no valid pulse after release.
  - Required: a fresh start is accepted normally.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and the
// counter-width helper.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Bits needed to count 0 .. value-1 (minimum 1).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res = 1;
    int unsigned v   = value - 1;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((v >> i) != 0) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/valid handshake and operand/result bus of the serial subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 4
) ();

  logic             i_w_start;
  logic [WIDTH-1:0] i_w_a;
  logic [WIDTH-1:0] i_w_b;
  logic             i_w_bin;
  logic             o_w_busy;
  logic             o_w_valid;
  logic [WIDTH-1:0] o_w_diff;
  logic             o_w_bout;

  modport master (
    output i_w_start, i_w_a, i_w_b, i_w_bin,
    input  o_w_busy, o_w_valid, o_w_diff, o_w_bout
  );

  modport slave (
    input  i_w_start, i_w_a, i_w_b, i_w_bin,
    output o_w_busy, o_w_valid, o_w_diff, o_w_bout
  );

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, bout set on underflow.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, A - B - Bin, LSB first, one bit per clock.
// Optional SERIAL_SUB_SATURATE_EN clamps an underflowing result to zero.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic               i_w_clk,
  input  logic               i_w_rst_n,
  serial_subtractor_if.slave bus
);

  localparam int unsigned      CntW    = clog2(WIDTH);
  localparam logic [CntW-1:0]  CntLast = CntW'(WIDTH - 1);

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-2:0] part_q;
  logic             br_q;
  logic             busy_q;
  logic             valid_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;

  logic             cell_d;
  logic             cell_bout;
  logic [WIDTH-1:0] part_full;
  logic [WIDTH-1:0] diff_next;

  full_subtractor u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Partial result with the current bit entering at the MSB.
  assign part_full = {cell_d, part_q};

`ifdef SERIAL_SUB_SATURATE_EN
  assign diff_next = cell_bout ? '0 : part_full;
`else
  assign diff_next = part_full;
`endif

  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      br_q    <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          valid_q <= 1'b0;
          if (bus.i_w_start) begin
            state_q <= ST_SHIFT;
            busy_q  <= 1'b1;
            a_q     <= bus.i_w_a;
            b_q     <= bus.i_w_b;
            br_q    <= bus.i_w_bin;
            cnt_q   <= '0;
            part_q  <= '0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          // Start is deliberately not looked at here.
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          br_q   <= cell_bout;
          part_q <= (WIDTH-1)'(part_full >> 1);
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            diff_q  <= diff_next;
            bout_q  <= cell_bout;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_w_busy  = busy_q;
  assign bus.o_w_valid = valid_q;
  assign bus.o_w_diff  = diff_q;
  assign bus.o_w_bout  = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4), honours SERIAL_SUB_SATURATE_EN.
module tb_serial_subtractor;

  localparam int unsigned W = 4;

`ifdef SERIAL_SUB_SATURATE_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .i_w_clk   (clk),
    .i_w_rst_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] diff;  // wrapped result
    logic       bout;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  function automatic int exp_diff(input logic [3:0] wrapped, input logic bout);
    return (Sat && bout) ? 0 : int'(wrapped);
  endfunction

  // Issue one start, scramble operands afterwards, wait for valid.
  task automatic run_op(input vec_t v, output logic [3:0] d, output logic bo,
                        output int lat, output int busy_n);
    @(negedge clk);
    bus.i_w_start = 1'b1;
    bus.i_w_a     = v.a;
    bus.i_w_b     = v.b;
    bus.i_w_bin   = v.bin;
    @(negedge clk);
    bus.i_w_start = 1'b0;
    bus.i_w_a     = ~v.a;
    bus.i_w_b     = ~v.b;
    bus.i_w_bin   = ~v.bin;
    lat    = 1;
    busy_n = int'(bus.o_w_busy);
    while (!bus.o_w_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.o_w_busy) busy_n++;
    end
    d  = bus.o_w_diff;
    bo = bus.o_w_bout;
  endtask

  initial begin
    logic [3:0] d, d2;
    logic       bo, bo2;
    int         lat, busy_n, pulses, k, gap;

    bus.i_w_start = 1'b0;
    bus.i_w_a     = '0;
    bus.i_w_b     = '0;
    bus.i_w_bin   = 1'b0;

    #12;
    check("reset_busy",  int'(bus.o_w_busy),  0);
    check("reset_valid", int'(bus.o_w_valid), 0);
    check("reset_diff",  int'(bus.o_w_diff),  0);
    check("reset_bout",  int'(bus.o_w_bout),  0);
    @(negedge clk);
    rst_n = 1'b1;

    vecs[0] = '{4'h9, 4'h3, 1'b0, 4'h6, 1'b0};
    vecs[1] = '{4'h3, 4'h9, 1'b0, 4'hA, 1'b1};
    vecs[2] = '{4'h0, 4'h0, 1'b1, 4'hF, 1'b1};
    vecs[3] = '{4'hF, 4'hE, 1'b0, 4'h1, 1'b0};
    vecs[4] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1};
    vecs[5] = '{4'h8, 4'h7, 1'b1, 4'h0, 1'b0};
    vecs[6] = '{4'h5, 4'h5, 1'b0, 4'h0, 1'b0};

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i], d, bo, lat, busy_n);
      check($sformatf("vec%0d_diff", i), int'(d), exp_diff(vecs[i].diff, vecs[i].bout));
      check($sformatf("vec%0d_bout", i), int'(bo), int'(vecs[i].bout));
      check($sformatf("vec%0d_latency", i), lat, W + 1);
      check($sformatf("vec%0d_busy_cycles", i), busy_n, W);
      @(negedge clk);
      check($sformatf("vec%0d_valid_drop", i), int'(bus.o_w_valid), 0);
    end

    // Start pulsed during SHIFT must be ignored.
    @(negedge clk);
    bus.i_w_start = 1'b1; bus.i_w_a = 4'h5; bus.i_w_b = 4'h1; bus.i_w_bin = 1'b0;
    @(negedge clk);
    bus.i_w_start = 1'b0;
    @(negedge clk);
    bus.i_w_start = 1'b1; bus.i_w_a = 4'hF; bus.i_w_b = 4'h0;
    @(negedge clk);
    bus.i_w_start = 1'b0;
    pulses = 0; d = '0; bo = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.o_w_valid) begin
        pulses++;
        if (pulses == 1) begin d = bus.o_w_diff; bo = bus.o_w_bout; end
      end
    end
    check("ignored_start_pulses", pulses, 1);
    check("ignored_start_diff", int'(d), 4);
    check("ignored_start_bout", int'(bo), 0);

    // Back-to-back: start held through DONE.
    @(negedge clk);
    bus.i_w_start = 1'b1; bus.i_w_a = 4'h9; bus.i_w_b = 4'h3; bus.i_w_bin = 1'b0;
    @(negedge clk);
    bus.i_w_a = 4'hF; bus.i_w_b = 4'hE;
    k = 0;
    while (!bus.o_w_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    d = bus.o_w_diff;
    check("b2b_first_diff", int'(d), 6);
    @(negedge clk);
    bus.i_w_start = 1'b0;
    gap = 1;
    while (!bus.o_w_valid && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    d2 = bus.o_w_diff; bo2 = bus.o_w_bout;
    check("b2b_gap", gap, W + 1);
    check("b2b_second_diff", int'(d2), 1);
    check("b2b_second_bout", int'(bo2), 0);
    @(negedge clk);

    // Reset two cycles into SHIFT.
    @(negedge clk);
    bus.i_w_start = 1'b1; bus.i_w_a = 4'h9; bus.i_w_b = 4'h3;
    @(negedge clk);
    bus.i_w_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("busy_before_reset", int'(bus.o_w_busy), 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_busy",  int'(bus.o_w_busy),  0);
    check("async_reset_valid", int'(bus.o_w_valid), 0);
    check("async_reset_diff",  int'(bus.o_w_diff),  0);
    check("async_reset_bout",  int'(bus.o_w_bout),  0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.o_w_valid) pulses++;
    end
    check("no_valid_after_abort", pulses, 0);

    run_op('{4'h7, 4'h2, 1'b0, 4'h5, 1'b0}, d, bo, lat, busy_n);
    check("fresh_diff", int'(d), 5);
    check("fresh_bout", int'(bo), 0);
    check("fresh_latency", lat, W + 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
